axis_x2_arbiter: RTL and testbench

Shares one `axis_x2` squaring pipeline between `N_CHANNELS` independent AXI-stream requesters. Grants the shared input a whole packet at a time (round-robin, packet boundary = `last`), records the owner of each granted packet in an in-order tag FIFO, and routes the squarer's output back to the matching channel. Sits between the per-channel sample sources and the single `axis_x2` instance, which it drives through `to_x2` and receives from through `from_x2`.

---
 rtl/axis_x2_arb_pkg.sv | 22 ++
 rtl/axis_x2_tag_fifo.sv | 83 ++++++++
 rtl/axis_x2_arbiter.sv | 171 +++++++++++++++++
 tb/tb_axis_x2_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_x2_arb_pkg.sv
// -----------------------------------------------------------------------------
// axis_x2_arb_pkg
// Shared types and helpers for the axis_x2 arbiter slice.
//   state_t  : arbiter input-side state (IDLE / BUSY)
//   chan_w() : width of a channel index, $clog2(n) with a minimum of one bit.
// The channel-index type itself depends on the instance's channel count, so
// each module declares its own chan_idx_t from chan_w(N_CHANNELS).
// -----------------------------------------------------------------------------
package axis_x2_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int STAT_W = 32;

    function automatic int chan_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_x2_tag_fifo.sv
// -----------------------------------------------------------------------------
// axis_x2_tag_fifo
// In-order FIFO of channel tags, one entry per packet granted to the shared
// squarer. Head is read combinationally so a tag is visible as soon as it is
// written. full/empty are registered; push and pop in the same cycle both
// take effect and leave the occupancy unchanged.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   push_i, push_tag_i  write a tag (ignored while full)
//   pop_i             drop the head entry (ignored while empty)
//   head_o            current head tag
//   full_o, empty_o   registered occupancy flags
// DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module axis_x2_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic [CW-1:0] push_tag_i,
    input  logic          pop_i,
    output logic [CW-1:0] head_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full_q;
    logic          empty_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_tag_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == (AW + 1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/axis_x2_arbiter.sv
// -----------------------------------------------------------------------------
// axis_x2_arbiter
// Shares one axis_x2 squarer between N_CHANNELS AXI-stream requesters.
// Input side: whole-packet round-robin grant (IDLE picks, BUSY forwards the
// granted channel until its last beat). Each grant pushes the owner into an
// in-order tag FIFO; the FIFO head steers the squarer output back to the
// owning channel and is popped on each output last beat.
// Ports (streams flattened to data/valid/last/ready, DW = SAMPLE_WIDTH *
// PARALLEL_SAMPLES):
//   clk, reset_n        clock, asynchronous active-low reset
//   data_in_*           per-channel input streams (slave)
//   data_out_*          per-channel squared output streams (master)
//   to_x2_*             shared squarer input (master)
//   from_x2_*           shared squarer output (slave)
//   err_orphan_o        sticky: squarer output valid while no tag is queued
//   pkt_count_o         per-channel delivered-packet counters, only present
//                       when AXIS_X2_ARBITER_STATS_EN is defined
// -----------------------------------------------------------------------------
module axis_x2_arbiter
    import axis_x2_arb_pkg::*;
#(
    parameter int N_CHANNELS         = 4,
    parameter int SAMPLE_WIDTH       = 16,
    parameter int PARALLEL_SAMPLES   = 2,
    parameter int MAX_PKTS_IN_FLIGHT = 8
) (
    input  logic                                                    clk,
    input  logic                                                    reset_n,
    input  logic [N_CHANNELS-1:0][SAMPLE_WIDTH*PARALLEL_SAMPLES-1:0] data_in_data_i,
    input  logic [N_CHANNELS-1:0]                                   data_in_valid_i,
    input  logic [N_CHANNELS-1:0]                                   data_in_last_i,
    output logic [N_CHANNELS-1:0]                                   data_in_ready_o,
    output logic [N_CHANNELS-1:0][SAMPLE_WIDTH*PARALLEL_SAMPLES-1:0] data_out_data_o,
    output logic [N_CHANNELS-1:0]                                   data_out_valid_o,
    output logic [N_CHANNELS-1:0]                                   data_out_last_o,
    input  logic [N_CHANNELS-1:0]                                   data_out_ready_i,
    output logic [SAMPLE_WIDTH*PARALLEL_SAMPLES-1:0]                to_x2_data_o,
    output logic                                                    to_x2_valid_o,
    output logic                                                    to_x2_last_o,
    input  logic                                                    to_x2_ready_i,
    input  logic [SAMPLE_WIDTH*PARALLEL_SAMPLES-1:0]                from_x2_data_i,
    input  logic                                                    from_x2_valid_i,
    input  logic                                                    from_x2_last_i,
    output logic                                                    from_x2_ready_o,
`ifdef AXIS_X2_ARBITER_STATS_EN
    output logic [N_CHANNELS-1:0][STAT_W-1:0]                       pkt_count_o,
`endif
    output logic                                                    err_orphan_o
);

    localparam int CW = chan_w(N_CHANNELS);
    typedef logic [CW-1:0] chan_idx_t;

    state_t    state_q;
    chan_idx_t grant_q;
    chan_idx_t rr_ptr_q;
    chan_idx_t rr_ptr_d;
    logic      err_orphan_q;

    chan_idx_t pick_idx;
    chan_idx_t cand;
    logic      pick_found;
    logic      grant_fire;
    logic      busy;
    logic      in_last_fire;

    chan_idx_t tag_head;
    logic      tag_full;
    logic      tag_empty;
    logic      tag_pop;

    // First valid channel at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            cand = chan_idx_t'((int'(rr_ptr_q) + i) % N_CHANNELS);
            if (!pick_found && data_in_valid_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign busy         = (state_q == BUSY);
    // Registered full flag: a pop in this cycle cannot enable a grant in it.
    assign grant_fire   = (state_q == IDLE) && pick_found && !tag_full;
    assign in_last_fire = to_x2_valid_o && to_x2_ready_i && to_x2_last_o;
    assign rr_ptr_d     = (grant_q == chan_idx_t'(N_CHANNELS - 1)) ? '0
                                                                   : chan_idx_t'(grant_q + 1'b1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        grant_q <= pick_idx;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (in_last_fire) begin
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (tag_empty && from_x2_valid_i) begin
                err_orphan_q <= 1'b1;
            end
        end
    end

    // Granted channel passes straight through to the squarer.
    assign to_x2_valid_o = busy && data_in_valid_i[grant_q];
    assign to_x2_data_o  = busy ? data_in_data_i[grant_q] : '0;
    assign to_x2_last_o  = busy && data_in_last_i[grant_q];

    assign from_x2_ready_o = !tag_empty && data_out_ready_i[tag_head];
    assign tag_pop         = from_x2_valid_i && from_x2_ready_o && from_x2_last_i;
    assign err_orphan_o    = err_orphan_q;

    axis_x2_tag_fifo #(
        .DEPTH (MAX_PKTS_IN_FLIGHT),
        .CW    (CW)
    ) u_tag_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (grant_fire),
        .push_tag_i (pick_idx),
        .pop_i      (tag_pop),
        .head_o     (tag_head),
        .full_o     (tag_full),
        .empty_o    (tag_empty)
    );

    for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_chan
        logic out_sel;
        assign out_sel              = !tag_empty && (tag_head == chan_idx_t'(gi));
        assign data_in_ready_o[gi]  = busy && (grant_q == chan_idx_t'(gi)) && to_x2_ready_i;
        assign data_out_valid_o[gi] = out_sel && from_x2_valid_i;
        assign data_out_data_o[gi]  = out_sel ? from_x2_data_i : '0;
        assign data_out_last_o[gi]  = out_sel && from_x2_last_i;
    end

`ifdef AXIS_X2_ARBITER_STATS_EN
    logic [N_CHANNELS-1:0][STAT_W-1:0] pkt_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt_q <= '0;
        end else begin
            for (int k = 0; k < N_CHANNELS; k++) begin
                if (data_out_valid_o[k] && data_out_ready_i[k] && data_out_last_o[k]) begin
                    pkt_cnt_q[k] <= pkt_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign pkt_count_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axis_x2_arbiter.sv
module tb_axis_x2_arbiter;

    localparam int N     = 4;
    localparam int SW    = 16;
    localparam int PS    = 2;
    localparam int DW    = SW * PS;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset_n;
    logic [N-1:0][DW-1:0]  data_in_data;
    logic [N-1:0]          data_in_valid;
    logic [N-1:0]          data_in_last;
    logic [N-1:0]          data_in_ready;
    logic [N-1:0][DW-1:0]  data_out_data;
    logic [N-1:0]          data_out_valid;
    logic [N-1:0]          data_out_last;
    logic [N-1:0]          data_out_ready;
    logic [DW-1:0]         to_x2_data;
    logic                  to_x2_valid;
    logic                  to_x2_last;
    logic                  to_x2_ready;
    logic [DW-1:0]         from_x2_data;
    logic                  from_x2_valid;
    logic                  from_x2_last;
    logic                  from_x2_ready;
    logic                  err_orphan;
`ifdef AXIS_X2_ARBITER_STATS_EN
    logic [N-1:0][31:0]    pkt_count;
`endif

    axis_x2_arbiter #(
        .N_CHANNELS         (N),
        .SAMPLE_WIDTH       (SW),
        .PARALLEL_SAMPLES   (PS),
        .MAX_PKTS_IN_FLIGHT (DEPTH)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .data_in_data_i   (data_in_data),
        .data_in_valid_i  (data_in_valid),
        .data_in_last_i   (data_in_last),
        .data_in_ready_o  (data_in_ready),
        .data_out_data_o  (data_out_data),
        .data_out_valid_o (data_out_valid),
        .data_out_last_o  (data_out_last),
        .data_out_ready_i (data_out_ready),
        .to_x2_data_o     (to_x2_data),
        .to_x2_valid_o    (to_x2_valid),
        .to_x2_last_o     (to_x2_last),
        .to_x2_ready_i    (to_x2_ready),
        .from_x2_data_i   (from_x2_data),
        .from_x2_valid_i  (from_x2_valid),
        .from_x2_last_i   (from_x2_last),
        .from_x2_ready_o  (from_x2_ready),
`ifdef AXIS_X2_ARBITER_STATS_EN
        .pkt_count_o      (pkt_count),
`endif
        .err_orphan_o     (err_orphan)
    );

    // ---------------- bench state ----------------
    logic [DW:0] src_q   [N][$];   // {last, data} per channel source
    logic [DW:0] sq_q    [$];      // squarer model pipeline contents
    logic [DW:0] exp_out [N][$];   // squared beats each channel must receive
    int          tags[$];          // owners of packets in flight, oldest first
    int          m_owner;          // channel holding the input, -1 if none
    int          m_rr;
    logic        m_err;
    int          grant_log[$];
    int          deliver_log[$];
    int          last_pos0[$];
    int          recv_beats[N];
    int          recv_last[N];
    logic [DW-1:0] first_out0, last_out0;
    bit          got_first0;

    logic [N-1:0] src_en, dout_rdy;
    logic         x2_rdy, sq_en, force_orphan;

    int  n_checks = 0;
    int  n_pass   = 0;

    bit   c_in_fire, c_out_fire, c_from_v;
    int   c_head;
    logic [DW:0] c_in_beat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] sq(input logic [DW-1:0] d);
        logic [DW-1:0]   r;
        logic [2*SW-1:0] prod;
        r = '0;
        for (int p = 0; p < PS; p++) begin
            prod = {{SW{1'b0}}, d[p*SW +: SW]} * {{SW{1'b0}}, d[p*SW +: SW]};
            r[p*SW +: SW] = prod[SW-1:0];
        end
        return r;
    endfunction

    function automatic bit model_busy();
        bit b;
        b = (sq_q.size() != 0) || (tags.size() != 0) || (m_owner >= 0);
        for (int k = 0; k < N; k++) if (src_q[k].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            if (src_en[k] && src_q[k].size() > 0) begin
                data_in_valid[k] = 1'b1;
                {data_in_last[k], data_in_data[k]} = src_q[k][0];
            end else begin
                data_in_valid[k] = 1'b0;
                data_in_last[k]  = 1'b0;
                data_in_data[k]  = '0;
            end
        end
        if (force_orphan) begin
            from_x2_valid = 1'b1;
            from_x2_data  = 32'hDEAD_BEEF;
            from_x2_last  = 1'b1;
        end else if (sq_en && sq_q.size() > 0) begin
            from_x2_valid = 1'b1;
            {from_x2_last, from_x2_data} = sq_q[0];
        end else begin
            from_x2_valid = 1'b0;
            from_x2_last  = 1'b0;
            from_x2_data  = '0;
        end
        to_x2_ready    = x2_rdy;
        data_out_ready = dout_rdy;
    endtask

    // Compare every DUT output against the routing rules for the current cycle.
    task automatic compare();
        logic         exp_tv, exp_fr;
        logic [N-1:0] exp_ir, exp_ov;
        int           head;
        exp_tv = (m_owner >= 0) ? data_in_valid[m_owner] : 1'b0;
        chk("to_x2.valid", {63'd0, to_x2_valid}, {63'd0, exp_tv});
        if (exp_tv) begin
            chk("to_x2.data", 64'(to_x2_data), 64'(data_in_data[m_owner]));
            chk("to_x2.last", {63'd0, to_x2_last}, {63'd0, data_in_last[m_owner]});
        end
        exp_ir = '0;
        if (m_owner >= 0 && x2_rdy) exp_ir[m_owner] = 1'b1;
        chk("data_in.ready", 64'(data_in_ready), 64'(exp_ir));
        head   = (tags.size() > 0) ? tags[0] : -1;
        exp_fr = (head >= 0) ? dout_rdy[head] : 1'b0;
        chk("from_x2.ready", {63'd0, from_x2_ready}, {63'd0, exp_fr});
        exp_ov = '0;
        if (head >= 0 && from_x2_valid) exp_ov[head] = 1'b1;
        chk("data_out.valid", 64'(data_out_valid), 64'(exp_ov));
        if (head >= 0 && from_x2_valid) begin
            chk("data_out.data", 64'(data_out_data[head]), 64'(from_x2_data));
            chk("data_out.last", {63'd0, data_out_last[head]}, {63'd0, from_x2_last});
        end
        chk("err_orphan", {63'd0, err_orphan}, {63'd0, m_err});

        c_in_fire  = exp_tv && x2_rdy;
        c_in_beat  = (m_owner >= 0) ? {data_in_last[m_owner], data_in_data[m_owner]} : '0;
        c_head     = head;
        c_from_v   = from_x2_valid;
        c_out_fire = (head >= 0) && from_x2_valid && dout_rdy[head];
        if (c_out_fire) begin
            n_checks++;
            if (exp_out[head].size() == 0) begin
                $display("FAIL e2e ch%0d: got beat 0x%0h, expected none", head, data_out_data[head]);
            end else if ({data_out_last[head], data_out_data[head]} === exp_out[head][0]) begin
                n_pass++;
            end else begin
                $display("FAIL e2e ch%0d: got 0x%0h, expected 0x%0h", head,
                         {data_out_last[head], data_out_data[head]}, exp_out[head][0]);
            end
        end
    endtask

    task automatic update_model();
        int  pre_size;
        bit  found;
        int  c;
        logic [DW:0] beat;
        pre_size = tags.size();
        if (c_out_fire) begin
            beat = sq_q.pop_front();
            if (exp_out[c_head].size() > 0) void'(exp_out[c_head].pop_front());
            recv_beats[c_head]++;
            if (c_head == 0) begin
                if (!got_first0) first_out0 = beat[DW-1:0];
                got_first0 = 1'b1;
                last_out0  = beat[DW-1:0];
            end
            if (beat[DW]) begin
                void'(tags.pop_front());
                recv_last[c_head]++;
                deliver_log.push_back(c_head);
                if (c_head == 0) last_pos0.push_back(recv_beats[0]);
                $display("deliver ch%0d packet %0d (%0d beats so far)", c_head, recv_last[c_head],
                         recv_beats[c_head]);
            end
        end
        if (c_from_v && pre_size == 0) m_err = 1'b1;
        if (m_owner < 0) begin
            if (pre_size < DEPTH) begin
                found = 1'b0;
                for (int i = 0; i < N; i++) begin
                    c = (m_rr + i) % N;
                    if (!found && data_in_valid[c]) begin
                        found   = 1'b1;
                        m_owner = c;
                    end
                end
                if (found) begin
                    tags.push_back(m_owner);
                    grant_log.push_back(m_owner);
                end
            end
        end else if (c_in_fire) begin
            void'(src_q[m_owner].pop_front());
            beat = {c_in_beat[DW], sq(c_in_beat[DW-1:0])};
            sq_q.push_back(beat);
            exp_out[m_owner].push_back(beat);
            if (c_in_beat[DW]) begin
                m_rr    = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick();
        drive_inputs();
        #1;
        compare();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic run_until_done(input string name, input int bound);
        int c;
        c = 0;
        while (model_busy() && c < bound) begin
            tick();
            c++;
        end
        n_checks++;
        if (!model_busy()) n_pass++;
        else $display("FAIL %s drain: got still busy after %0d cycles, expected idle", name, bound);
    endtask

    // Called at a falling edge: asynchronous assert, checks, release at a falling edge.
    task automatic do_reset(input string name);
        #3 reset_n = 1'b0;
        #1;
        chk({name, " rst to_x2.valid"}, {63'd0, to_x2_valid}, 64'd0);
        chk({name, " rst data_in.ready"}, 64'(data_in_ready), 64'd0);
        chk({name, " rst data_out.valid"}, 64'(data_out_valid), 64'd0);
        chk({name, " rst from_x2.ready"}, {63'd0, from_x2_ready}, 64'd0);
        chk({name, " rst err_orphan"}, {63'd0, err_orphan}, 64'd0);
        for (int k = 0; k < N; k++) begin
            src_q[k].delete();
            exp_out[k].delete();
            recv_beats[k] = 0;
            recv_last[k]  = 0;
        end
        sq_q.delete();
        tags.delete();
        grant_log.delete();
        deliver_log.delete();
        last_pos0.delete();
        got_first0   = 1'b0;
        m_owner      = -1;
        m_rr         = 0;
        m_err        = 1'b0;
        force_orphan = 1'b0;
        src_en = '1; dout_rdy = '1; x2_rdy = 1'b1; sq_en = 1'b1;
        @(negedge clk);
        drive_inputs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin : main
        logic [63:0] pk;
        reset_n = 1'b1;
        src_en = '1; dout_rdy = '1; x2_rdy = 1'b1; sq_en = 1'b1; force_orphan = 1'b0;
        m_owner = -1; m_rr = 0; m_err = 1'b0;
        data_in_data = '0; data_in_valid = '0; data_in_last = '0;
        from_x2_data = '0; from_x2_valid = 1'b0; from_x2_last = 1'b0;
        to_x2_ready = 1'b1; data_out_ready = '1;
        @(negedge clk);

        // A: channel 0, three 4-beat packets
        do_reset("A");
        for (int i = 0; i < 12; i++)
            src_q[0].push_back({(i % 4 == 3) ? 1'b1 : 1'b0, 16'(5 + i), 16'(3 + i)});
        run_until_done("A", 200);
        chk("A ch0 beats", 64'(recv_beats[0]), 64'd12);
        chk("A ch0 packets", 64'(recv_last[0]), 64'd3);
        pk = 0;
        foreach (last_pos0[i]) pk = (pk << 8) | 64'(last_pos0[i]);
        chk("A last positions", pk, 64'h04080C);
        chk("A first squared beat", 64'(first_out0), 64'h0019_0009);
        chk("A final squared beat", 64'(last_out0), 64'h0100_00C4);
        chk("A other channels beats", 64'(recv_beats[1] + recv_beats[2] + recv_beats[3]), 64'd0);

        // B: all channels, 1-beat packets, round-robin from 0
        do_reset("B");
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++)
                src_q[k].push_back({1'b1, 16'(k * 10 + r + 1), 16'(k + 2)});
        run_until_done("B", 200);
        pk = 0;
        foreach (grant_log[i]) pk = (pk << 4) | 64'(grant_log[i]);
        chk("B grant order", pk, 64'h0123_0123);
        for (int k = 0; k < N; k++) chk("B per-channel packets", 64'(recv_last[k]), 64'd2);

        // C: output blocked, 10 queued packets, tag FIFO limits grants to 8
        do_reset("C");
        for (int i = 0; i < 10; i++) src_q[i % N].push_back({1'b1, 16'(i + 1), 16'(i + 7)});
        dout_rdy = '0;
        repeat (60) tick();
        chk("C grants while blocked", 64'(grant_log.size()), 64'd8);
        chk("C delivered while blocked", 64'(deliver_log.size()), 64'd0);
        dout_rdy = '1;
        run_until_done("C", 300);
        chk("C total grants", 64'(grant_log.size()), 64'd10);
        pk = 0;
        foreach (deliver_log[i]) pk = (pk << 4) | 64'(deliver_log[i]);
        chk("C delivery order", pk, 64'h01_2301_2301);

        // D: random valid/ready on all channels
        do_reset("D");
        for (int k = 0; k < N; k++)
            for (int p = 0; p < 15; p++) begin
                int len;
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++)
                    src_q[k].push_back({(b == len - 1) ? 1'b1 : 1'b0, 32'($urandom)});
            end
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < N; k++) begin
                src_en[k]   = ($urandom_range(0, 3) != 0);
                dout_rdy[k] = ($urandom_range(0, 3) != 0);
            end
            x2_rdy = ($urandom_range(0, 3) != 0);
            sq_en  = ($urandom_range(0, 2) != 0);
            tick();
        end
        src_en = '1; dout_rdy = '1; x2_rdy = 1'b1; sq_en = 1'b1;
        run_until_done("D", 3000);
        for (int k = 0; k < N; k++) begin
            chk("D packets per channel", 64'(recv_last[k]), 64'd15);
            chk("D leftover expected beats", 64'(exp_out[k].size()), 64'd0);
`ifdef AXIS_X2_ARBITER_STATS_EN
            chk("D pkt_count", 64'(pkt_count[k]), 64'd15);
`endif
        end
        chk("D err_orphan", {63'd0, err_orphan}, 64'd0);

        // E: squarer output with nothing in flight
        do_reset("E");
        force_orphan = 1'b1;
        tick();
        chk("E err_orphan set", {63'd0, err_orphan}, 64'd1);
        force_orphan = 1'b0;
        repeat (5) tick();
        chk("E err_orphan sticky", {63'd0, err_orphan}, 64'd1);

        // F: reset in the middle of a packet, then a clean packet on channel 0
        do_reset("F");
        for (int b = 0; b < 4; b++) src_q[1].push_back({(b == 3) ? 1'b1 : 1'b0, 16'(b + 1), 16'(b + 2)});
        for (int c = 0; c < 20 && src_q[1].size() > 2; c++) tick();
        chk("F beats taken before reset", 64'(src_q[1].size()), 64'd2);
        do_reset("F2");
        src_q[0].push_back({1'b0, 16'd2, 16'd4});
        src_q[0].push_back({1'b1, 16'd6, 16'd8});
        run_until_done("F", 100);
        chk("F ch0 beats", 64'(recv_beats[0]), 64'd2);
        chk("F ch1 beats", 64'(recv_beats[1]), 64'd0);
        chk("F first grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd0);
        chk("F last squared beat", 64'(last_out0), 64'h0024_0040);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
